// File: rtl/signed_step_accumulator.sv
// rtl/signed_step_accumulator.sv - debounced add/subtract signed accumulator with sign/magnitude output
module signed_step_accumulator #(
    parameter int NBITS     = 3,
    parameter int DB_CYCLES = 3
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] operand,
    input  logic             btn_add,
    input  logic             btn_sub,
    input  logic             clear,
    output logic [NBITS-1:0] value,
    output logic             neg,
    output logic [NBITS-1:0] mag,
    output logic             ovf,
    output logic             done
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    add_cnt;
    logic [CW-1:0]    sub_cnt;
    logic             add_deb;
    logic             sub_deb;
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] op_val;
    logic             op_sub;
    logic [NBITS:0]   acc_ext;
    logic [NBITS:0]   op_ext;
    logic [NBITS:0]   sum;

    // Add button debouncer: level flips once raw has disagreed for DB_CYCLES edges in a row
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            add_cnt <= '0;
            add_deb <= 1'b0;
        end else if (btn_add == add_deb) begin
            add_cnt <= '0;
        end else if (add_cnt == CNT_LAST) begin
            add_cnt <= '0;
            add_deb <= ~add_deb;
        end else begin
            add_cnt <= add_cnt + CW'(1);
        end
    end

    // Subtract button debouncer, same behaviour as the add side
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sub_cnt <= '0;
            sub_deb <= 1'b0;
        end else if (btn_sub == sub_deb) begin
            sub_cnt <= '0;
        end else if (sub_cnt == CNT_LAST) begin
            sub_cnt <= '0;
            sub_deb <= ~sub_deb;
        end else begin
            sub_cnt <= sub_cnt + CW'(1);
        end
    end

    // One-bit-wider signed arithmetic so overflow shows up as disagreement of the top two bits
    always_comb begin
        acc_ext = {acc[NBITS-1], acc};
        op_ext  = {op_val[NBITS-1], op_val};
        sum     = op_sub ? (acc_ext - op_ext) : (acc_ext + op_ext);
    end

    // Press FSM: accept one operation per press, then wait in HOLD until both buttons are released
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            op_val <= '0;
            op_sub <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                acc <= '0;
                ovf <= 1'b0;
                // An operation about to execute is dropped; the press still has to be released
                if (state == EXEC) begin
                    state <= HOLD;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (add_deb && sub_deb) begin
                            state <= HOLD;
                        end else if (add_deb) begin
                            op_sub <= 1'b0;
                            op_val <= operand;
                            state  <= EXEC;
                        end else if (sub_deb) begin
                            op_sub <= 1'b1;
                            op_val <= operand;
                            state  <= EXEC;
                        end
                    end
                    EXEC: begin
                        acc   <= sum[NBITS-1:0];
                        ovf   <= sum[NBITS] ^ sum[NBITS-1];
                        done  <= 1'b1;
                        state <= HOLD;
                    end
                    HOLD: begin
                        if (!add_deb && !sub_deb) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign value = acc;
    assign neg   = acc[NBITS-1];
    // The most negative value negates to itself, which reads correctly as unsigned 2^(NBITS-1)
    assign mag   = neg ? (~acc + NBITS'(1)) : acc;

endmodule

// File: tb/tb_signed_step_accumulator.sv
// tb/tb_signed_step_accumulator.sv - randomized self-checking bench for signed_step_accumulator
module tb_signed_step_accumulator;

    localparam int N    = 3;
    localparam int DB   = 3;
    localparam int MINV = -(1 << (N - 1));
    localparam int MAXV = (1 << (N - 1)) - 1;

    logic         clk_2 = 1'b0;
    logic         reset;
    logic [N-1:0] operand;
    logic         btn_add;
    logic         btn_sub;
    logic         clear;
    logic [N-1:0] value;
    logic         neg;
    logic [N-1:0] mag;
    logic         ovf;
    logic         done;

    int tests = 0;
    int fails = 0;

    // Reference state: accumulator as a plain signed integer and the last overflow flag
    int acc_m = 0;
    bit ovf_m = 1'b0;

    signed_step_accumulator #(.NBITS(N), .DB_CYCLES(DB)) dut (
        .clk_2  (clk_2),
        .reset  (reset),
        .operand(operand),
        .btn_add(btn_add),
        .btn_sub(btn_sub),
        .clear  (clear),
        .value  (value),
        .neg    (neg),
        .mag    (mag),
        .ovf    (ovf),
        .done   (done)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    function automatic int wrap(input int s);
        int r;
        r = s % (1 << N);
        if (r < 0) r += (1 << N);
        if (r > MAXV) r -= (1 << N);
        return r;
    endfunction

    function automatic logic [N-1:0] bits_of(input int v);
        int t;
        t = v;
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] abs_of(input int v);
        int t;
        t = (v < 0) ? -v : v;
        return t[N-1:0];
    endfunction

    // One full press/release cycle with timing, result and operand-capture checks
    task automatic do_press(input bit is_sub, input int op, input int hold_extra, input bit other_in_hold);
        int s;
        s = is_sub ? (acc_m - op) : (acc_m + op);
        operand = bits_of(op);
        btn_add = !is_sub;
        btn_sub = is_sub;
        for (int e = 1; e <= DB + 2 + hold_extra; e++) begin
            tick();
            if (e == DB + 1) operand = N'($urandom);
            if (e == DB + 3 && other_in_hold) begin
                btn_add = 1'b1;
                btn_sub = 1'b1;
            end
            tests++;
            if (done !== (e == DB + 2)) begin
                fails++;
                $display("FAIL press_done edge=%0d got=%b exp=%b", e, done, (e == DB + 2));
            end
            if (e == DB + 2) begin
                acc_m = wrap(s);
                ovf_m = (s > MAXV) || (s < MINV);
                tests++;
                if (value !== bits_of(acc_m) || ovf !== ovf_m || neg !== (acc_m < 0) || mag !== abs_of(acc_m)) begin
                    fails++;
                    $display("FAIL press_result got value=%b ovf=%b neg=%b mag=%b exp value=%b ovf=%b neg=%b mag=%b",
                             value, ovf, neg, mag, bits_of(acc_m), ovf_m, (acc_m < 0), abs_of(acc_m));
                end
            end
        end
        btn_add = 1'b0;
        btn_sub = 1'b0;
        for (int e = 1; e <= DB + 1; e++) begin
            tick();
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL release_done edge=%0d got=%b exp=0", e, done);
            end
        end
        tests++;
        if (value !== bits_of(acc_m) || ovf !== ovf_m) begin
            fails++;
            $display("FAIL release_hold got value=%b ovf=%b exp value=%b ovf=%b", value, ovf, bits_of(acc_m), ovf_m);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clear   = 1'b0;
        btn_add = 1'b0;
        btn_sub = 1'b0;
        operand = '0;
        tick();
        tick();
        tests++;
        if ({value, neg, mag, ovf, done} !== '0) begin
            fails++;
            $display("FAIL reset_values got value=%b neg=%b mag=%b ovf=%b done=%b exp all 0", value, neg, mag, ovf, done);
        end
        reset = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
        tick();
    endtask

    task automatic test_basic_add();
        do_press(1'b0, 3, 20, 1'b0);
    endtask

    task automatic test_overflow();
        do_press(1'b0, 1, 2, 1'b0);
        tests++;
        if (value !== 3'b100 || neg !== 1'b1 || mag !== 3'd4 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_wrap got value=%b neg=%b mag=%0d ovf=%b exp 100 1 4 1", value, neg, mag, ovf);
        end
        do_press(1'b1, 1, 1, 1'b0);
        do_press(1'b0, -1, 0, 1'b0);
        tests++;
        if (value !== 3'd2 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear_by_op got value=%b ovf=%b exp 010 0", value, ovf);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk_2);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({value, neg, mag, ovf, done} !== '0) begin
            fails++;
            $display("FAIL async_reset got value=%b neg=%b mag=%b ovf=%b done=%b exp all 0", value, neg, mag, ovf, done);
        end
        acc_m = 0;
        ovf_m = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_most_negative_sub();
        do_press(1'b1, MINV, 0, 1'b0);
        tests++;
        if (value !== 3'b100 || ovf !== 1'b1 || mag !== 3'd4) begin
            fails++;
            $display("FAIL most_neg_sub got value=%b ovf=%b mag=%0d exp 100 1 4", value, ovf, mag);
        end
    endtask

    task automatic test_bounce();
        btn_add = 1'b1;
        tick();
        tick();
        btn_add = 1'b0;
        tick();
        btn_add = 1'b1;
        tick();
        tick();
        btn_add = 1'b0;
        for (int i = 0; i < DB + 4; i++) begin
            tick();
            tests++;
            if (done !== 1'b0 || value !== bits_of(acc_m)) begin
                fails++;
                $display("FAIL bounce got done=%b value=%b exp done=0 value=%b", done, value, bits_of(acc_m));
            end
        end
    endtask

    task automatic test_both_buttons();
        btn_add = 1'b1;
        btn_sub = 1'b1;
        operand = 3'd1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 8) btn_add = 1'b0;
            tests++;
            if (done !== 1'b0 || value !== bits_of(acc_m)) begin
                fails++;
                $display("FAIL both_buttons cycle=%0d got done=%b value=%b exp done=0 value=%b", i, done, value, bits_of(acc_m));
            end
        end
        btn_sub = 1'b0;
        for (int i = 0; i < DB + 1; i++) tick();
        do_press(1'b0, 1, 0, 1'b0);
    endtask

    task automatic test_clear_in_exec();
        operand = 3'd2;
        btn_add = 1'b1;
        for (int i = 0; i < DB + 1; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
        tests++;
        if (value !== '0 || ovf !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL clear_exec got value=%b ovf=%b done=%b exp 000 0 0", value, ovf, done);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (done !== 1'b0 || value !== '0) begin
                fails++;
                $display("FAIL clear_held cycle=%0d got done=%b value=%b exp 0 000", i, done, value);
            end
        end
        btn_add = 1'b0;
        for (int i = 0; i < DB + 1; i++) tick();
        do_press(1'b0, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                btn_sub = 1'($urandom_range(0, 1));
                btn_add = !btn_sub;
                for (int g = 0; g < int'($urandom_range(1, DB - 1)); g++) tick();
                btn_add = 1'b0;
                btn_sub = 1'b0;
                for (int i = 0; i < DB + 1; i++) begin
                    tick();
                    tests++;
                    if (done !== 1'b0) begin
                        fails++;
                        $display("FAIL rand_glitch iter=%0d got done=%b exp 0", it, done);
                    end
                end
            end
            do_press(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << N) - 1)) + MINV,
                     int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_overflow();
        test_async_reset();
        test_most_negative_sub();
        test_bounce();
        test_both_buttons();
        test_clear_in_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
